// File: rtl/shadow_ray_dispatcher_pkg.sv
// Shared types for the shadow-ray dispatcher slice: the surface-stage payload,
// the output FSM state encoding and the default lane count.
package shadow_ray_dispatcher_pkg;

  localparam int SHADOW_LANES_DEFAULT = 4;

  typedef struct packed {
    logic             bHit;
    logic [7:0]       tag;
    logic [2:0][31:0] hitPos;
    logic [2:0][15:0] normal;
    logic [15:0]      materialId;
  } SurfaceOutputData;

  typedef enum logic {
    OS_Wait,
    OS_Emit
  } DispatchOutState;

endpackage

// File: rtl/shadow_lane_result_slot.sv
// One-deep capture register for a single generator lane's result; the lane is
// held off through o_lane_output_fifo_full until the dispatcher retires the slot.
module shadow_lane_result_slot
  import shadow_ray_dispatcher_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_lane_valid,
  input  SurfaceOutputData i_lane_out,
  input  logic             i_clear,
  output logic             o_res_full,
  output SurfaceOutputData o_res_buf,
  output logic             o_lane_output_fifo_full
);

  logic             r_resFull;
  SurfaceOutputData r_resBuf;

  // A lane result arriving while the slot is still occupied is dropped so the
  // older, in-order result is never overwritten.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_resFull <= 1'b0;
      r_resBuf  <= '0;
    end else if (i_clear) begin
      r_resFull <= 1'b0;
    end else if (i_lane_valid && !r_resFull) begin
      r_resFull <= 1'b1;
      r_resBuf  <= i_lane_out;
    end
  end

  assign o_res_full              = r_resFull;
  assign o_res_buf               = r_resBuf;
  assign o_lane_output_fifo_full = r_resFull;

`ifndef SYNTHESIS
  a_noOverwrite : assert property (@(posedge clk) disable iff (!resetn)
    !(i_lane_valid && r_resFull));
`endif

endmodule

// File: rtl/shadow_ray_dispatcher.sv
// Round-robin spreader of surface items over NUM_LANES shadow-ray generator lanes,
// re-serialising results in input order. Optional counters: SHADOW_DISPATCH_STATS_EN.
module shadow_ray_dispatcher
  import shadow_ray_dispatcher_pkg::*;
#(
  parameter int NUM_LANES = SHADOW_LANES_DEFAULT,
  parameter int PTR_W     = $clog2(NUM_LANES)
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                add_input,
  input  SurfaceOutputData                    input_data,
  output logic                                fifo_full,
  input  logic                                output_fifo_full,
  output logic                                valid,
  output SurfaceOutputData                    out,
  output logic             [NUM_LANES-1:0]    lane_add_input,
  output SurfaceOutputData                    lane_input_data,
  input  logic             [NUM_LANES-1:0]    lane_fifo_full,
  input  logic             [NUM_LANES-1:0]    lane_valid,
  input  SurfaceOutputData [NUM_LANES-1:0]    lane_out,
  output logic             [NUM_LANES-1:0]    lane_output_fifo_full
`ifdef SHADOW_DISPATCH_STATS_EN
  ,
  output logic             [31:0]             stat_dispatched,
  output logic             [31:0]             stat_retired,
  output logic             [31:0]             stat_stall_cycles
`endif
);

  logic [PTR_W-1:0]     r_dispPtr;
  logic [PTR_W-1:0]     r_collPtr;
  logic [NUM_LANES-1:0] r_busy;
  DispatchOutState      r_state;
  logic                 r_valid;
  SurfaceOutputData     r_out;
  logic [NUM_LANES-1:0] r_laneAdd;
  SurfaceOutputData     r_laneData;

  DispatchOutState      w_stateNext;
  logic                 w_accept;
  logic                 w_retire;
  logic [NUM_LANES-1:0] w_resFull;
  SurfaceOutputData     w_resBuf [NUM_LANES];

  // The busy bit covers the gap between dispatch and the lane raising its own full flag.
  assign fifo_full = r_busy[r_dispPtr] | lane_fifo_full[r_dispPtr];
  assign w_accept  = add_input && !fifo_full;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_slot
    shadow_lane_result_slot u_slot (
      .clk                     (clk),
      .resetn                  (resetn),
      .i_lane_valid            (lane_valid[g]),
      .i_lane_out              (lane_out[g]),
      .i_clear                 (w_retire && (r_collPtr == PTR_W'(g))),
      .o_res_full              (w_resFull[g]),
      .o_res_buf               (w_resBuf[g]),
      .o_lane_output_fifo_full (lane_output_fifo_full[g])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dispPtr  <= '0;
      r_laneAdd  <= '0;
      r_laneData <= '0;
    end else begin
      r_laneAdd <= '0;
      if (w_accept) begin
        r_laneAdd[r_dispPtr] <= 1'b1;
        r_laneData           <= input_data;
        r_dispPtr            <= r_dispPtr + PTR_W'(1);
      end
    end
  end

  // Dispatch only targets a non-busy lane and retirement only a busy one, so the
  // two never collide on the same bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (w_accept && (r_dispPtr == PTR_W'(i))) begin
          r_busy[i] <= 1'b1;
        end else if (w_retire && (r_collPtr == PTR_W'(i))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= OS_Wait;
      r_collPtr <= '0;
      r_valid   <= 1'b0;
      r_out     <= '0;
    end else begin
      r_state <= w_stateNext;
      r_valid <= w_retire;
      if (w_retire) begin
        r_out     <= w_resBuf[r_collPtr];
        r_collPtr <= r_collPtr + PTR_W'(1);
      end
    end
  end

  // The Emit state enforces a dead cycle after every output pulse.
  always_comb begin
    w_stateNext = r_state;
    w_retire    = 1'b0;
    case (r_state)
      OS_Wait: begin
        if (w_resFull[r_collPtr] && !output_fifo_full) begin
          w_retire    = 1'b1;
          w_stateNext = OS_Emit;
        end
      end
      OS_Emit: w_stateNext = OS_Wait;
      default: w_stateNext = OS_Wait;
    endcase
  end

  assign valid           = r_valid;
  assign out             = r_out;
  assign lane_add_input  = r_laneAdd;
  assign lane_input_data = r_laneData;

`ifdef SHADOW_DISPATCH_STATS_EN
  logic [31:0] r_statDispatched;
  logic [31:0] r_statRetired;
  logic [31:0] r_statStall;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_statDispatched <= '0;
      r_statRetired    <= '0;
      r_statStall      <= '0;
    end else begin
      if (w_accept && (r_statDispatched != '1)) r_statDispatched <= r_statDispatched + 32'd1;
      if (w_retire && (r_statRetired != '1))    r_statRetired    <= r_statRetired + 32'd1;
      if (add_input && fifo_full && (r_statStall != '1)) r_statStall <= r_statStall + 32'd1;
    end
  end

  assign stat_dispatched   = r_statDispatched;
  assign stat_retired      = r_statRetired;
  assign stat_stall_cycles = r_statStall;
`endif

endmodule

// File: tb/tb_shadow_ray_dispatcher.sv
// Self-checking bench for shadow_ray_dispatcher: behavioural lane models, an
// input-order scoreboard and per-scenario tasks with randomized payloads.
module tb_shadow_ray_dispatcher;
  import shadow_ray_dispatcher_pkg::*;

  localparam int NL = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic add_input = 1'b0;
  SurfaceOutputData input_data = '0;
  logic fifo_full;
  logic output_fifo_full;
  logic valid;
  SurfaceOutputData out;
  logic [NL-1:0] lane_add_input;
  SurfaceOutputData lane_input_data;
  logic [NL-1:0] lane_fifo_full;
  logic [NL-1:0] lane_valid;
  SurfaceOutputData [NL-1:0] lane_out;
  logic [NL-1:0] lane_output_fifo_full;
`ifdef SHADOW_DISPATCH_STATS_EN
  logic [31:0] stat_dispatched;
  logic [31:0] stat_retired;
  logic [31:0] stat_stall_cycles;
`endif

  logic bpForce = 1'b0;
  logic bpRand = 1'b0;
  logic bpRandEn = 1'b0;
  assign output_fifo_full = bpForce | bpRand;

  int tests = 0;
  int fails = 0;
  int dispCount = 0;
  int validCount = 0;
  SurfaceOutputData expQ[$];

  int laneLat[NL];
  int laneCnt[NL];
  logic [NL-1:0] laneBusy;
  SurfaceOutputData laneData[NL];
  assign lane_fifo_full = laneBusy;

  shadow_ray_dispatcher #(.NUM_LANES(NL)) dut (
    .clk                   (clk),
    .resetn                (resetn),
    .add_input             (add_input),
    .input_data            (input_data),
    .fifo_full             (fifo_full),
    .output_fifo_full      (output_fifo_full),
    .valid                 (valid),
    .out                   (out),
    .lane_add_input        (lane_add_input),
    .lane_input_data       (lane_input_data),
    .lane_fifo_full        (lane_fifo_full),
    .lane_valid            (lane_valid),
    .lane_out              (lane_out),
    .lane_output_fifo_full (lane_output_fifo_full)
`ifdef SHADOW_DISPATCH_STATS_EN
    ,
    .stat_dispatched       (stat_dispatched),
    .stat_retired          (stat_retired),
    .stat_stall_cycles     (stat_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) bpRand = bpRandEn && ($urandom_range(0, 2) == 0);

  // Generator lane model: one item at a time, fixed latency, stalls on backpressure.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      laneBusy   <= '0;
      lane_valid <= '0;
      lane_out   <= '0;
      for (int i = 0; i < NL; i++) laneCnt[i] <= 0;
    end else begin
      for (int i = 0; i < NL; i++) begin
        lane_valid[i] <= 1'b0;
        if (lane_add_input[i] && !laneBusy[i]) begin
          laneBusy[i] <= 1'b1;
          laneData[i] <= lane_input_data;
          laneCnt[i]  <= laneLat[i];
        end else if (laneBusy[i]) begin
          if (laneCnt[i] > 1) begin
            laneCnt[i] <= laneCnt[i] - 1;
          end else if (!lane_output_fifo_full[i]) begin
            lane_valid[i] <= 1'b1;
            lane_out[i]   <= laneData[i];
            laneBusy[i]   <= 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic SurfaceOutputData mkItem(input logic [7:0] tag, input logic hit);
    SurfaceOutputData d;
    d.bHit = hit;
    d.tag = tag;
    for (int i = 0; i < 3; i++) begin
      d.hitPos[i] = $urandom;
      d.normal[i] = 16'($urandom);
    end
    d.materialId = 16'($urandom);
    return d;
  endfunction

  task automatic setLatAll(input int lat);
    for (int i = 0; i < NL; i++) laneLat[i] = lat;
  endtask

  // Every output pulse must match the oldest accepted item and be isolated.
  task automatic watchOutputs();
    logic prevValid;
    SurfaceOutputData e;
    prevValid = 1'b0;
    forever begin
      @(negedge clk);
      if (resetn && valid === 1'b1) begin
        validCount++;
        tests++;
        if (expQ.size() == 0) begin
          fails++;
          $display("[TB] FAIL out_unexpected: got tag %0h, required no output", out.tag);
        end else begin
          e = expQ.pop_front();
          if (out !== e) begin
            fails++;
            $display("[TB] FAIL out_order: got tag %0h bHit %0b, required tag %0h bHit %0b",
                     out.tag, out.bHit, e.tag, e.bHit);
          end
        end
        tests++;
        if (prevValid) begin
          fails++;
          $display("[TB] FAIL valid_spacing: got valid high on consecutive cycles, required gap");
        end
      end
      prevValid = resetn && (valid === 1'b1);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting clock edge.
  task automatic sendItem(input SurfaceOutputData d, output int stalls);
    logic [NL-1:0] expMask;
    stalls = 0;
    add_input = 1'b1;
    input_data = d;
    while (fifo_full !== 1'b0 && stalls < 400) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 400) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout: got fifo_full %0b for 400 cycles, required accept", fifo_full);
      add_input = 1'b0;
      return;
    end
    @(negedge clk);
    add_input = 1'b0;
    expMask = NL'(1) << (dispCount % NL);
    expQ.push_back(d);
    dispCount++;
    tests++;
    if (lane_add_input !== expMask) begin
      fails++;
      $display("[TB] FAIL dispatch_lane: got %b, required %b", lane_add_input, expMask);
    end
    tests++;
    if (lane_input_data !== d) begin
      fails++;
      $display("[TB] FAIL dispatch_data: got tag %0h, required tag %0h", lane_input_data.tag, d.tag);
    end
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((expQ.size() != 0 || laneBusy != '0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (expQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain_timeout: got %0d items outstanding, required 0", expQ.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    tests++; if (valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b, required 0", valid); end
    tests++; if (fifo_full !== 1'b0) begin fails++; $display("[TB] FAIL reset_fifo_full: got %b, required 0", fifo_full); end
    tests++; if (lane_add_input !== '0) begin fails++; $display("[TB] FAIL reset_lane_add: got %b, required 0", lane_add_input); end
    tests++; if (out !== '0) begin fails++; $display("[TB] FAIL reset_out: got tag %0h, required all zero", out.tag); end
    tests++; if (lane_input_data !== '0) begin fails++; $display("[TB] FAIL reset_lane_data: got tag %0h, required all zero", lane_input_data.tag); end
    tests++; if (lane_output_fifo_full !== '0) begin fails++; $display("[TB] FAIL reset_lane_ofull: got %b, required 0", lane_output_fifo_full); end
  endtask

  task automatic test_single();
    int stalls;
    int v0;
    setLatAll(5);
    v0 = validCount;
    sendItem(mkItem(8'h11, 1'b1), stalls);
    tests++; if (fifo_full !== 1'b0) begin fails++; $display("[TB] FAIL single_fifo_full: got %b, required 0", fifo_full); end
    drain();
    tests++; if (validCount - v0 != 1) begin fails++; $display("[TB] FAIL single_count: got %0d outputs, required 1", validCount - v0); end
  endtask

  task automatic test_back_to_back();
    int stalls[8];
    int v0;
    setLatAll(20);
    v0 = validCount;
    for (int i = 0; i < 8; i++) sendItem(mkItem(8'(i + 1), 1'($urandom)), stalls[i]);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (stalls[i] != 0) begin fails++; $display("[TB] FAIL b2b_early_stall: item %0d got %0d stalls, required 0", i + 1, stalls[i]); end
    end
    tests++; if (stalls[4] == 0) begin fails++; $display("[TB] FAIL b2b_full: item 5 got 0 stalls, required fifo_full after 4 accepts"); end
    drain();
    tests++; if (validCount - v0 != 8) begin fails++; $display("[TB] FAIL b2b_count: got %0d outputs, required 8", validCount - v0); end
  endtask

  task automatic test_out_of_order();
    int stalls;
    int slow;
    int v0;
    logic [NL-1:0] expHold;
    slow = dispCount % NL;
    setLatAll(5);
    laneLat[slow] = 30;
    v0 = validCount;
    for (int i = 0; i < 4; i++) sendItem(mkItem(8'(8'h21 + i), 1'b1), stalls);
    repeat (15) @(negedge clk);
    expHold = ~(NL'(1) << slow);
    tests++; if (lane_output_fifo_full !== expHold) begin fails++; $display("[TB] FAIL ooo_hold: got %b, required %b", lane_output_fifo_full, expHold); end
    tests++; if (validCount != v0) begin fails++; $display("[TB] FAIL ooo_early_out: got %0d outputs, required 0", validCount - v0); end
    drain();
  endtask

  task automatic test_backpressure();
    int stalls;
    int v0;
    int cyc;
    int prev;
    int w;
    for (int i = 0; i < NL; i++) laneLat[i] = $urandom_range(3, 10);
    bpForce = 1'b1;
    v0 = validCount;
    for (int i = 0; i < 4; i++) sendItem(mkItem(8'($urandom), 1'($urandom)), stalls);
    repeat (50) @(negedge clk);
    tests++; if (validCount != v0) begin fails++; $display("[TB] FAIL bp_no_out: got %0d outputs, required 0", validCount - v0); end
    tests++; if (lane_output_fifo_full !== '1) begin fails++; $display("[TB] FAIL bp_all_full: got %b, required 1111", lane_output_fifo_full); end
    bpForce = 1'b0;
    cyc = 0;
    prev = -100;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      do begin
        @(negedge clk);
        cyc++;
        w++;
      end while (valid !== 1'b1 && w < 20);
      tests++;
      if (valid !== 1'b1) begin
        fails++;
        $display("[TB] FAIL bp_release: got no output %0d, required a pulse within 20 cycles", k);
      end else if (k > 0) begin
        tests++;
        if (cyc - prev != 2) begin fails++; $display("[TB] FAIL bp_spacing: got gap %0d, required 2", cyc - prev); end
      end
      prev = cyc;
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int stalls;
    setLatAll(30);
    for (int i = 0; i < 3; i++) sendItem(mkItem(8'(8'h41 + i), 1'b1), stalls);
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    expQ.delete();
    dispCount = 0;
    tests++; if (valid !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_valid: got %b, required 0", valid); end
    tests++; if (fifo_full !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_fifo_full: got %b, required 0", fifo_full); end
    tests++; if (lane_output_fifo_full !== '0) begin fails++; $display("[TB] FAIL rstmid_lane_ofull: got %b, required 0", lane_output_fifo_full); end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    setLatAll(4);
    sendItem(mkItem(8'h55, 1'b0), stalls);
    drain();
  endtask

  task automatic test_random();
    int stalls;
    int v0;
    for (int i = 0; i < NL; i++) laneLat[i] = $urandom_range(1, 12);
    v0 = validCount;
    bpRandEn = 1'b1;
    for (int i = 0; i < 24; i++) begin
      sendItem(mkItem(8'($urandom), 1'($urandom)), stalls);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    bpRandEn = 1'b0;
    drain();
    tests++; if (validCount - v0 != 24) begin fails++; $display("[TB] FAIL rand_count: got %0d outputs, required 24", validCount - v0); end
  endtask

`ifdef SHADOW_DISPATCH_STATS_EN
  task automatic test_stats();
    int stalls;
    int stallSum;
    @(negedge clk);
    #2 resetn = 1'b0;
    expQ.delete();
    dispCount = 0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    tests++; if (stat_dispatched !== 32'd0) begin fails++; $display("[TB] FAIL stats_reset: got %0d, required 0", stat_dispatched); end
    setLatAll(20);
    stallSum = 0;
    for (int i = 0; i < 6; i++) begin
      sendItem(mkItem(8'(8'h61 + i), 1'b1), stalls);
      stallSum += stalls;
    end
    drain();
    tests++; if (stat_dispatched !== 32'd6) begin fails++; $display("[TB] FAIL stats_dispatched: got %0d, required 6", stat_dispatched); end
    tests++; if (stat_retired !== 32'd6) begin fails++; $display("[TB] FAIL stats_retired: got %0d, required 6", stat_retired); end
    tests++; if (stat_stall_cycles !== 32'(stallSum)) begin fails++; $display("[TB] FAIL stats_stall: got %0d, required %0d", stat_stall_cycles, stallSum); end
  endtask
`endif

  initial begin
    setLatAll(5);
    fork
      watchOutputs();
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_out_of_order();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef SHADOW_DISPATCH_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
